// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle RV32 control sequencer.
// Watchdog support is compiled in only when MC_MEM_TIMEOUT_EN is defined.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CLS_R  = 2'd0,
    CLS_I  = 2'd1,
    CLS_LD = 2'd2,
    CLS_ST = 2'd3
  } iclass_t;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;

  localparam logic [1:0] ALUOP_I   = 2'b00;
  localparam logic [1:0] ALUOP_MEM = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  function automatic logic [1:0] alu_op_for(iclass_t c);
    case (c)
      CLS_R:   return ALUOP_R;
      CLS_I:   return ALUOP_I;
      default: return ALUOP_MEM;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_watchdog.sv
// Memory-wait watchdog: counts stalled FETCH/MEM cycles and flags expiry.
// Instantiated by the top only when MC_MEM_TIMEOUT_EN is defined.
module mc_mem_watchdog #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  input  logic clear,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_reg;

  // clear fires on every state change, so the count restarts on entry to a wait state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_reg <= '0;
    else if (clear)
      cnt_reg <= '0;
    else if (active && !ready)
      cnt_reg <= cnt_reg + CW'(1);
  end

  assign expire = active && !ready && (cnt_reg == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 core.
// Define MC_MEM_TIMEOUT_EN to enable the memory-wait watchdog trap.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instret
);

  state_t            state_reg, state_next;
  iclass_t           class_reg, class_next;
  logic [CNT_W-1:0]  instret_reg;
  logic              illegal_reg, timeout_reg;
  logic              retire, set_illegal, set_timeout;
  logic              waiting, expire;

  assign waiting = (state_reg == S_FETCH) || (state_reg == S_MEM);

`ifdef MC_MEM_TIMEOUT_EN
  mc_mem_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .active (waiting),
    .ready  (mem_ready),
    .clear  (state_next != state_reg),
    .expire (expire)
  );
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    class_next  = class_reg;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state_reg)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (expire) begin
          state_next  = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        state_next = S_EXEC;
        case (opcode)
          OPC_R:  class_next = CLS_R;
          OPC_I:  class_next = CLS_I;
          OPC_LD: class_next = CLS_LD;
          OPC_ST: class_next = CLS_ST;
          default: begin
            state_next  = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_EXEC: state_next = (class_reg == CLS_LD || class_reg == CLS_ST) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready) begin
          if (class_reg == CLS_ST) begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end else begin
            state_next = S_WB;
          end
        end else if (expire) begin
          state_next  = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_IDLE;
    endcase
  end

  // Control word is Moore except the IR/PC strobes, which complete with the fetch
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        alu_src = (class_reg != CLS_R);
        alu_op  = alu_op_for(class_reg);
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (class_reg == CLS_ST);
        alu_src  = 1'b1;
        alu_op   = alu_op_for(class_reg);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_reg == CLS_LD);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      class_reg   <= CLS_R;
      instret_reg <= '0;
      illegal_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      class_reg   <= class_next;
      illegal_reg <= illegal_reg | set_illegal;
      timeout_reg <= timeout_reg | set_timeout;
      if (retire)
        instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  assign state       = state_reg;
  assign illegal     = illegal_reg;
  assign mem_timeout = timeout_reg;
  assign instret     = instret_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller plus corner-case sequences.
// Define MC_MEM_TIMEOUT_EN to exercise the watchdog trap instead of the endless wait.
module tb_multicycle_controller;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  // {mem_req, mem_we, addr_sel, ir_write, pc_write, alu_src, alu_op[1:0], reg_write, mem_to_reg}
  localparam logic [9:0] C0   = 10'b0000000000;
  localparam logic [9:0] C_F0 = 10'b1000000000;
  localparam logic [9:0] C_F1 = 10'b1001100000;
  localparam logic [9:0] C_ER = 10'b0000001000;
  localparam logic [9:0] C_EI = 10'b0000010000;
  localparam logic [9:0] C_EM = 10'b0000010100;
  localparam logic [9:0] C_ML = 10'b1010010100;
  localparam logic [9:0] C_MS = 10'b1110010100;
  localparam logic [9:0] C_WB = 10'b0000000010;
  localparam logic [9:0] C_WL = 10'b0000000011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_write, pc_write, alu_src;
  logic [1:0]  alu_op;
  logic        reg_write, mem_to_reg, illegal, mem_timeout;
  logic [2:0]  state;
  logic [31:0] instret;
  logic [9:0]  ctrl;

  int errors = 0;
  int checks = 0;

  multicycle_controller #(.CNT_W(32), .TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .state      (state),
    .illegal    (illegal),
    .mem_timeout(mem_timeout),
    .instret    (instret)
  );

  assign ctrl = {mem_req, mem_we, addr_sel, ir_write, pc_write, alu_src, alu_op, reg_write, mem_to_reg};

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  op;
    logic        rdy;
    logic [2:0]  st;
    logic [9:0]  ctrl;
    logic [31:0] ic;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [6:0] op, logic rdy, logic [2:0] st, logic [9:0] c, logic [31:0] ic);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctrl = c; v.ic = ic;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hung expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Instruction stream: R, I (with a fetch stall), load (3-cycle MEM stall), store.
    vecs.push_back(mk(R,  1'b1, 3'd0, C0,   0));
    vecs.push_back(mk(R,  1'b1, 3'd1, C_F1, 0));
    vecs.push_back(mk(R,  1'b1, 3'd2, C0,   0));
    vecs.push_back(mk(R,  1'b1, 3'd3, C_ER, 0));
    vecs.push_back(mk(R,  1'b1, 3'd5, C_WB, 0));
    vecs.push_back(mk(I,  1'b0, 3'd1, C_F0, 1));
    vecs.push_back(mk(I,  1'b1, 3'd1, C_F1, 1));
    vecs.push_back(mk(I,  1'b1, 3'd2, C0,   1));
    vecs.push_back(mk(I,  1'b1, 3'd3, C_EI, 1));
    vecs.push_back(mk(I,  1'b0, 3'd5, C_WB, 1));
    vecs.push_back(mk(LD, 1'b1, 3'd1, C_F1, 2));
    vecs.push_back(mk(LD, 1'b0, 3'd2, C0,   2));
    vecs.push_back(mk(LD, 1'b0, 3'd3, C_EM, 2));
    vecs.push_back(mk(LD, 1'b0, 3'd4, C_ML, 2));
    vecs.push_back(mk(LD, 1'b0, 3'd4, C_ML, 2));
    vecs.push_back(mk(LD, 1'b0, 3'd4, C_ML, 2));
    vecs.push_back(mk(LD, 1'b1, 3'd4, C_ML, 2));
    vecs.push_back(mk(LD, 1'b1, 3'd5, C_WL, 2));
    vecs.push_back(mk(ST, 1'b1, 3'd1, C_F1, 3));
    vecs.push_back(mk(ST, 1'b1, 3'd2, C0,   3));
    vecs.push_back(mk(ST, 1'b1, 3'd3, C_EM, 3));
    vecs.push_back(mk(ST, 1'b0, 3'd4, C_MS, 3));
    vecs.push_back(mk(ST, 1'b1, 3'd4, C_MS, 3));
    vecs.push_back(mk(ST, 1'b0, 3'd1, C_F0, 4));

    // Reset state
    step();
    chk("reset state", 32'(state), 32'd0);
    chk("reset ctrl", 32'(ctrl), 32'(C0));
    chk("reset instret", instret, 32'd0);
    chk("reset flags", 32'({illegal, mem_timeout}), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      opcode    = vecs[i].op;
      mem_ready = vecs[i].rdy;
      #1;
      $display("row %0d: op=%b rdy=%b state=%0d ctrl=%b instret=%0d", i, opcode, mem_ready, state, ctrl, instret);
      chk($sformatf("row%0d state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("row%0d ctrl", i), 32'(ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("row%0d instret", i), instret, vecs[i].ic);
      chk($sformatf("row%0d flags", i), 32'({illegal, mem_timeout}), 32'd0);
      step();
    end

    // Reset during a stalled store: request drops asynchronously.
    opcode = ST; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    step();
    chk("st_wait state", 32'(state), 32'd4);
    chk("st_wait mem_req", 32'(mem_req), 32'd1);
    chk("st_wait instret", instret, 32'd4);
    #2 rst = 1'b1;
    #1;
    $display("async reset in MEM: state=%0d mem_req=%b instret=%0d", state, mem_req, instret);
    chk("rst_mem mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem state", 32'(state), 32'd0);
    chk("rst_mem instret", instret, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst fetch", 32'(state), 32'd1);

    // Illegal opcode traps after DECODE and ignores memory.
    opcode = 7'b1111111; mem_ready = 1'b1;
    step();
    chk("ill decode", 32'(state), 32'd2);
    step();
    $display("illegal opcode: state=%0d illegal=%b ctrl=%b", state, illegal, ctrl);
    chk("ill trap state", 32'(state), 32'd6);
    chk("ill flag", 32'(illegal), 32'd1);
    chk("ill ctrl", 32'(ctrl), 32'(C0));
    for (int k = 0; k < 4; k++) begin
      mem_ready = k[0];
      step();
    end
    chk("ill hold state", 32'(state), 32'd6);
    chk("ill hold flag", 32'(illegal), 32'd1);
    chk("ill hold ctrl", 32'(ctrl), 32'(C0));
    rst = 1'b1;
    #1;
    chk("ill rst flag", 32'(illegal), 32'd0);
    chk("ill rst state", 32'(state), 32'd0);
    step();
    rst = 1'b0;
    mem_ready = 1'b0;
    opcode = R;
    step();
    chk("wait enter fetch", 32'(state), 32'd1);

`ifdef MC_MEM_TIMEOUT_EN
    step(); step(); step();
    chk("wd 3 waits", 32'(state), 32'd1);
    chk("wd 3 waits flag", 32'(mem_timeout), 32'd0);
    step();
    $display("watchdog: state=%0d mem_timeout=%b", state, mem_timeout);
    chk("wd trap", 32'(state), 32'd6);
    chk("wd flag", 32'(mem_timeout), 32'd1);
    mem_ready = 1'b1;
    step();
    chk("wd hold", 32'({state, mem_timeout}), 32'({3'd6, 1'b1}));
`else
    repeat (100) step();
    $display("no watchdog: state=%0d mem_req=%b mem_timeout=%b", state, mem_req, mem_timeout);
    chk("nowd fetch hold", 32'(state), 32'd1);
    chk("nowd mem_req", 32'(mem_req), 32'd1);
    chk("nowd flag", 32'(mem_timeout), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
